// File: rtl/sop_pkg.sv
// Shared types and constants for the sum-of-products sweep engine.
// No logic; state encoding, mode codes and the reference 4-input mask.
// Not applicable (no datapath).
package sop_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        EVAL  = 2'd1,
        SWEEP = 2'd2,
        FIN   = 2'd3
    } sop_state_e;

    localparam logic MODE_SINGLE = 1'b0;
    localparam logic MODE_SWEEP  = 1'b1;

    // F(W,X,Y,Z) = m(0,1,8,9,10,11,12,14,15)
    localparam logic [15:0] SOP_DEFAULT_MASK_4 = 16'hDF03;

endpackage

// File: rtl/sop_mask_lut.sv
// Selects one bit of a minterm mask: f = mask[idx].
// Combinational, zero cycles.
// No handshake; output follows inputs.
module sop_mask_lut #(
    parameter int N_IN = 4,
    localparam int MASK_W = 2 ** N_IN
) (
    input  logic [MASK_W-1:0] mask_i,
    input  logic [N_IN-1:0]   idx_i,
    output logic              f_o
);

    assign f_o = mask_i[idx_i];

endmodule

// File: rtl/sop_sweep_engine.sv
// Loadable minterm-mask function: single evaluation or full 2^N_IN sweep with ones count.
// First beat one cycle after start; out_f is combinational from registered mask/idx.
// Output beats hold while out_valid && !out_ready; start/mask_load dropped while busy.
module sop_sweep_engine
    import sop_pkg::*;
#(
    parameter int N_IN = 4,
    localparam int MASK_W = 2 ** N_IN,
    parameter logic [MASK_W-1:0] DEFAULT_MASK = MASK_W'(SOP_DEFAULT_MASK_4)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mask_load,
    input  logic [MASK_W-1:0] mask_in,
    input  logic              start,
    input  logic              mode,
    input  logic [N_IN-1:0]   eval_in,
    input  logic              out_ready,
    output logic              busy,
    output logic              out_valid,
    output logic [N_IN-1:0]   out_idx,
    output logic              out_f,
    output logic [N_IN:0]     ones_count,
    output logic              done
);

    localparam logic [N_IN-1:0] IDX_LAST = N_IN'(MASK_W - 1);

    sop_state_e        state_q, state_d;
    logic [MASK_W-1:0] mask_q, mask_d;
    logic [N_IN-1:0]   idx_q, idx_d;
    logic              vld_q, vld_d;
    logic [N_IN:0]     cnt_q, cnt_d;
    logic              lut_f;
    logic              xfer;

    sop_mask_lut #(.N_IN(N_IN)) u_lut (
        .mask_i (mask_q),
        .idx_i  (idx_q),
        .f_o    (lut_f)
    );

    assign xfer = vld_q && out_ready;

    // Next-state: mask is only writable in IDLE, so it can never change mid-operation.
    always_comb begin
        state_d = state_q;
        mask_d  = mask_q;
        idx_d   = idx_q;
        vld_d   = vld_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (mask_load) begin
                    mask_d = mask_in;
                end
                if (start) begin
                    vld_d = 1'b1;
                    if (mode == MODE_SWEEP) begin
                        state_d = SWEEP;
                        idx_d   = '0;
                        cnt_d   = '0;
                    end else begin
                        state_d = EVAL;
                        idx_d   = eval_in;
                    end
                end
            end
            EVAL: begin
                if (xfer) begin
                    vld_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            SWEEP: begin
                if (xfer) begin
                    cnt_d = cnt_q + {{N_IN{1'b0}}, lut_f};
                    if (idx_q == IDX_LAST) begin
                        vld_d   = 1'b0;
                        state_d = FIN;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers; reset aborts any sweep and restores the reference mask.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            mask_q  <= DEFAULT_MASK;
            idx_q   <= '0;
            vld_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            idx_q   <= idx_d;
            vld_q   <= vld_d;
            cnt_q   <= cnt_d;
        end
    end

    // out_f is qualified by valid so an idle engine shows 0 regardless of mask[out_idx].
    assign out_f      = vld_q & lut_f;
    assign out_valid  = vld_q;
    assign out_idx    = idx_q;
    assign ones_count = cnt_q;
    assign busy       = (state_q != IDLE);
    assign done       = (state_q == FIN);

endmodule

// File: tb/tb_sop_sweep_engine.sv
module tb_sop_sweep_engine;

    logic        clk;
    logic        rst_n;

    logic        mask_load, start, mode, out_ready;
    logic [15:0] mask_in;
    logic [3:0]  eval_in;
    logic        busy, out_valid, out_f, done;
    logic [3:0]  out_idx;
    logic [4:0]  ones_count;

    logic        b_mask_load, b_start, b_mode, b_out_ready;
    logic [3:0]  b_mask_in;
    logic [1:0]  b_eval_in;
    logic        b_busy, b_out_valid, b_out_f, b_done;
    logic [1:0]  b_out_idx;
    logic [2:0]  b_ones_count;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [15:0] model_mask;
    int          last_cnt;

    sop_sweep_engine dut (
        .clk(clk), .rst_n(rst_n), .mask_load(mask_load), .mask_in(mask_in),
        .start(start), .mode(mode), .eval_in(eval_in), .out_ready(out_ready),
        .busy(busy), .out_valid(out_valid), .out_idx(out_idx), .out_f(out_f),
        .ones_count(ones_count), .done(done)
    );

    sop_sweep_engine #(.N_IN(2), .DEFAULT_MASK(4'b1001)) dut2 (
        .clk(clk), .rst_n(rst_n), .mask_load(b_mask_load), .mask_in(b_mask_in),
        .start(b_start), .mode(b_mode), .eval_in(b_eval_in), .out_ready(b_out_ready),
        .busy(b_busy), .out_valid(b_out_valid), .out_idx(b_out_idx), .out_f(b_out_f),
        .ones_count(b_ones_count), .done(b_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int popcount16(input logic [15:0] m);
        int c = 0;
        for (int k = 0; k < 16; k++) c += int'(m[k]);
        return c;
    endfunction

    // One full sweep on the 4-input engine. stall_idx/stall_len hold out_ready low at one
    // index; rnd randomises out_ready; inject_idx pulses start+mask_load(0) mid-sweep.
    task automatic sweep4(input bit load, input logic [15:0] m, input int stall_idx,
                          input int stall_len, input bit rnd, input int inject_idx);
        int  cyc, exp_idx, stalls, stalled, done_cnt, done_cyc, exp_cnt;
        bit  r, injected;
        @(negedge clk);
        start = 1'b1; mode = 1'b1; mask_load = load; mask_in = m; out_ready = 1'b1;
        if (load) model_mask = m;
        exp_cnt = popcount16(model_mask);
        @(negedge clk);
        cyc = 1; exp_idx = 0; stalls = 0; stalled = 0; done_cnt = 0; done_cyc = -1;
        injected = 1'b0;
        while (cyc < 300 && !(exp_idx == 16 && done_cyc >= 0 && cyc > done_cyc + 1)) begin
            start = 1'b0; mask_load = 1'b0;
            if (done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            if (exp_idx < 16) begin
                check_eq("sw_valid", out_valid, 1);
                check_eq("sw_idx", out_idx, exp_idx);
                check_eq("sw_f", out_f, model_mask[exp_idx]);
                check_eq("sw_busy", busy, 1);
                if (exp_idx == stall_idx && stalled < stall_len) begin
                    r = 1'b0; stalled++;
                end else if (rnd) begin
                    r = ($urandom_range(0, 2) != 0);
                end else begin
                    r = 1'b1;
                end
                if (exp_idx == inject_idx && !injected) begin
                    start = 1'b1; mode = 1'b1; mask_load = 1'b1; mask_in = 16'h0000;
                    injected = 1'b1;
                end
                out_ready = r;
                if (r) exp_idx++; else stalls++;
            end else begin
                check_eq("sw_valid_end", out_valid, 0);
                out_ready = 1'(($urandom_range(0, 1)));
            end
            @(negedge clk);
            cyc++;
        end
        if (cyc >= 300) check_eq("sw_timeout", 0, 1);
        check_eq("sw_done_pulses", done_cnt, 1);
        check_eq("sw_done_cycle", done_cyc, 17 + stalls);
        check_eq("sw_count", ones_count, exp_cnt);
        check_eq("sw_idle", busy, 0);
        last_cnt = exp_cnt;
        out_ready = 1'b1;
    endtask

    // Single evaluation; consumer waits wait_cyc cycles before accepting.
    task automatic eval4(input logic [3:0] e, input int wait_cyc);
        @(negedge clk);
        start = 1'b1; mode = 1'b0; eval_in = e; out_ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i <= wait_cyc; i++) begin
            check_eq("ev_valid", out_valid, 1);
            check_eq("ev_idx", out_idx, e);
            check_eq("ev_f", out_f, model_mask[e]);
            check_eq("ev_done", done, 0);
            out_ready = (i == wait_cyc);
            @(negedge clk);
        end
        check_eq("ev_valid_end", out_valid, 0);
        check_eq("ev_busy_end", busy, 0);
        check_eq("ev_done_end", done, 0);
        check_eq("ev_count_kept", ones_count, last_cnt);
        out_ready = 1'b1;
    endtask

    // Full sweep on the 2-input engine with out_ready held high.
    task automatic sweep2(input logic [3:0] m2);
        int cyc, exp_idx, exp_cnt, done_cyc;
        exp_cnt = 0;
        for (int k = 0; k < 4; k++) exp_cnt += int'(m2[k]);
        @(negedge clk);
        b_start = 1'b1; b_mode = 1'b1; b_out_ready = 1'b1;
        @(negedge clk);
        b_start = 1'b0; cyc = 1; exp_idx = 0; done_cyc = -1;
        while (cyc < 50 && done_cyc < 0) begin
            if (b_done) done_cyc = cyc;
            if (exp_idx < 4) begin
                check_eq("b_idx", b_out_idx, exp_idx);
                check_eq("b_f", b_out_f, m2[exp_idx]);
                check_eq("b_busy", b_busy, 1);
                exp_idx++;
            end
            @(negedge clk);
            cyc++;
        end
        if (cyc >= 50) check_eq("b_timeout", 0, 1);
        check_eq("b_done_cycle", done_cyc, 5);
        check_eq("b_count", b_ones_count, exp_cnt);
        check_eq("b_done_clear", b_done, 0);
    endtask

    initial begin
        int guard;
        rst_n = 1'b0;
        mask_load = 0; start = 0; mode = 0; out_ready = 1; mask_in = '0; eval_in = '0;
        b_mask_load = 0; b_start = 0; b_mode = 0; b_out_ready = 1; b_mask_in = '0; b_eval_in = '0;
        model_mask = 16'hDF03;
        last_cnt = 0;
        repeat (3) @(negedge clk);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_valid", out_valid, 0);
        check_eq("rst_idx", out_idx, 0);
        check_eq("rst_f", out_f, 0);
        check_eq("rst_count", ones_count, 0);
        check_eq("rst_done", done, 0);
        rst_n = 1'b1;

        // Default function, then single evaluations
        sweep4(0, 16'h0, -1, 0, 0, -1);
        eval4(4'd13, 0);
        eval4(4'd12, 2);

        // Backpressure at idx 2
        sweep4(0, 16'h0, 2, 3, 0, -1);

        // Mask load with start, then all-ones mask
        sweep4(1, 16'h0001, -1, 0, 0, -1);
        eval4(4'd5, 1);
        sweep4(1, 16'hFFFF, -1, 0, 0, -1);
        check_eq("all_ones_count", ones_count, 5'b10000);

        // Restore default, then start/mask_load while busy must be dropped
        sweep4(1, 16'hDF03, -1, 0, 0, -1);
        sweep4(0, 16'h0, -1, 0, 0, 5);
        sweep4(0, 16'h0, -1, 0, 0, -1);

        // Randomised: masks loaded alone while idle, random backpressure, random evals
        for (int t = 0; t < 6; t++) begin
            @(negedge clk);
            mask_load = 1'b1; mask_in = 16'($urandom());
            model_mask = mask_in;
            @(negedge clk);
            mask_load = 1'b0;
            eval4(4'($urandom_range(0, 15)), $urandom_range(0, 3));
            sweep4(0, 16'h0, -1, 0, 1, -1);
            eval4(4'($urandom_range(0, 15)), $urandom_range(0, 2));
        end

        // Reset mid-sweep at idx 7
        @(negedge clk);
        start = 1'b1; mode = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        guard = 0;
        while (out_idx != 4'd7 && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 40) check_eq("mid_rst_timeout", 0, 1);
        #2 rst_n = 1'b0;
        #1;
        check_eq("mid_rst_busy", busy, 0);
        check_eq("mid_rst_valid", out_valid, 0);
        check_eq("mid_rst_idx", out_idx, 0);
        check_eq("mid_rst_f", out_f, 0);
        check_eq("mid_rst_count", ones_count, 0);
        check_eq("mid_rst_done", done, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq("mid_rst_no_done", done, 0);
        end
        rst_n = 1'b1;
        model_mask = 16'hDF03;
        last_cnt = 0;
        @(negedge clk);
        check_eq("post_rst_done", done, 0);
        sweep4(0, 16'h0, -1, 0, 0, -1);

        // Two-input instance: plain sweep, then reset mid-sweep and sweep again
        sweep2(4'b1001);
        @(negedge clk);
        b_start = 1'b1; b_mode = 1'b1;
        @(negedge clk);
        b_start = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_eq("b_rst_valid", b_out_valid, 0);
        check_eq("b_rst_busy", b_busy, 0);
        check_eq("b_rst_count", b_ones_count, 0);
        check_eq("b_rst_done", b_done, 0);
        @(negedge clk);
        rst_n = 1'b1;
        sweep2(4'b1001);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/sop_sweep_engine.md
Name: sop_sweep_engine

Overview:
- Parametrised, sequential successor to the team's fixed 4-input sum-of-minterms function F(W,X,Y,Z) = m(0,1,8,9,10,11,12,14,15).
- Holds the function as a loadable minterm mask. Evaluates either one input vector on request or sweeps all 2^N_IN combinations as a valid/ready output stream.
- Counts true minterms during a sweep and pulses done at the end.
- Sits between a stimulus/control source and a result consumer, such as a checker or display logger.

Parameters:
- N_IN, 4, number of function inputs (1..8); derived localparam MASK_W = 2**N_IN.
- DEFAULT_MASK, 16'hDF03, reset value of the mask; bit k = 1 means minterm k is in the function (16'hDF03 encodes m(0,1,8,9,10,11,12,14,15)).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- mask_load  in  1  load mask_in into the mask register.
- mask_in  in  MASK_W  new minterm mask.
- start  in  1  start request; accepted only in IDLE.
- mode  in  1  0 = single evaluation, 1 = full sweep; sampled with start.
- eval_in  in  N_IN  input vector for single evaluation; MSB = W; sampled with start.
- out_ready  in  1  consumer ready.
- busy  out  1  high in any state except IDLE.
- out_valid  out  1  result beat valid.
- out_idx  out  N_IN  input combination of the current beat.
- out_f  out  1  mask[out_idx].
- ones_count  out  N_IN+1  number of true beats in the current/last sweep.
- done  out  1  one-cycle pulse at sweep completion.

Behaviour:
- Reset (asynchronous, applied immediately):
  - mask = DEFAULT_MASK; state = IDLE.
  - busy, out_valid, out_idx, out_f, ones_count, done all 0.
  - Reset mid-sweep aborts the sweep: no done pulse, the partial count is discarded.
- States: IDLE, EVAL, SWEEP, FIN.
- IDLE:
  - mask_load = 1 -> mask <= mask_in.
  - start = 1 -> ones_count <= 0, unless mode = 0 (see below). If mask_load and start are in the same cycle, both are accepted and the evaluation uses mask_in.
  - start with mode = 0 -> EVAL: out_idx <= eval_in, out_valid <= 1.
  - start with mode = 1 -> SWEEP: out_idx <= 0, out_valid <= 1.
- Latency: first out_valid appears the cycle after start is accepted. out_f is combinational from the registered mask and out_idx.
- Handshake:
  - A beat transfers on a cycle with out_valid && out_ready.
  - While out_valid && !out_ready, out_idx and out_f hold stable; no beat is skipped or duplicated.
- EVAL: on transfer, out_valid <= 0 and state -> IDLE. ones_count is unchanged and done is not pulsed.
- SWEEP:
  - On each transfer, ones_count += out_f.
  - If out_idx != MASK_W-1, out_idx increments.
  - If out_idx == MASK_W-1, out_valid <= 0 and state -> FIN. No wrap to 0.
- FIN: done = 1 for exactly one cycle, ones_count is final, state -> IDLE.
- Result hold: ones_count holds until the next accepted start with mode = 1. out_idx holds its last value in IDLE.
- Busy conditions: start and mask_load are ignored (dropped, not queued) while busy. The mask is never changed mid-operation.
- Count range: ones_count ranges 0..MASK_W; all-ones mask gives MASK_W (e.g. 5'b10000 for N_IN = 4). No overflow.
- Throughput: with out_ready held high, a full sweep takes MASK_W beat cycles; done comes MASK_W+1 cycles after start.

Decomposition:
- Package sop_pkg holds:
  - state enum (IDLE, EVAL, SWEEP, FIN);
  - mode constants MODE_SINGLE = 1'b0 and MODE_SWEEP = 1'b1;
  - default mask constant SOP_DEFAULT_MASK_4 = 16'hDF03.
- One sub-module: sop_mask_lut, a purely combinational mask[idx] selector, parametrised by N_IN. It is reused by checkers.
- The FSM, counter and mask register stay in the top module.

Test Plan:
- Default sweep: release reset, start with mode = 1, out_ready = 1.
  - Required out_f for idx 0..15: 1,1,0,0,0,0,0,0,1,1,1,1,1,0,1,1.
  - ones_count = 9; done pulses once, 17 cycles after start.
- Single evaluation:
  - mode = 0, eval_in = 4'd13 -> one beat, out_idx = 13, out_f = 0; done stays 0 and ones_count is unchanged.
  - eval_in = 4'd12 -> out_f = 1.
- Backpressure: during a sweep, drop out_ready while out_idx = 2 for 3 cycles.
  - out_idx stays 2 and out_f stays 0 throughout.
  - Sequence continues at 3; final count 9; done 20 cycles after start.
- Mask load:
  - mask_load with 16'h0001, same cycle as start with mode = 1 -> only idx 0 gives out_f = 1; ones_count = 1.
  - Then load 16'hFFFF and sweep -> ones_count = 5'b10000.
- Ignore while busy:
  - Pulse start and mask_load = 16'h0000 at idx 5 of a default sweep.
  - Sweep completes unchanged with ones_count = 9; mask is still 16'hDF03 afterwards.
- Reset mid-sweep:
  - Assert rst_n low at idx 7 -> all outputs 0 immediately, no done pulse.
  - A new sweep after release gives ones_count = 9.
  - Repeat with an N_IN = 2 instance, DEFAULT_MASK = 4'b1001 -> out_f = 1,0,0,1 and ones_count = 2.
